// File: rtl/bit7_pkg.sv
// Shared constants for the 7-bit mux/demux family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bit7_pkg;

    localparam int WIDTH = 7;
    localparam int DEPTH = 2;

    // Route-select polarity, identical to the mux 'sl' input.
    localparam logic SEL_OUT1 = 1'b1;
    localparam logic SEL_OUT2 = 1'b0;

endpackage

// File: rtl/bit7_1to2_demux_if.sv
// Input stream plus both output channels of the 1-to-2 demux.
// Latency: n/a (wires only).
// Backpressure: in_ready from the demux, outN_ready from each consumer.
interface bit7_1to2_demux_if #(
    parameter int WIDTH = bit7_pkg::WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;

    // Producer and consumers side.
    modport master (
        output in_data, in_sel, in_valid, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_valid, out2_data, out2_valid
    );

    // Demux side.
    modport slave (
        input  in_data, in_sel, in_valid, out1_ready, out2_ready,
        output in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
endinterface

// File: rtl/bit7_1to2_demux_fifo.sv
// Pointer-based synchronous FIFO with wrap bit for full/empty.
// Latency: 1 cycle push-to-visible, no bypass when empty.
// Backpressure: push ignored when full, pop ignored when empty.
module bit7_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means every slot is occupied.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head slot only changes on a write into it, so dout is stable while empty.
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer and storage state; storage cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/bit7_1to2_demux.sv
// Steers a 7-bit valid/ready stream into two FIFO-buffered channels, with accept counters.
// Latency: 1 cycle from accepting edge to outN_valid; counters update 1 cycle after push/clear.
// Backpressure: in_ready = ~full of the selected channel only (head-of-line blocking).
module bit7_1to2_demux #(
    parameter int WIDTH = bit7_pkg::WIDTH,
    parameter int DEPTH = bit7_pkg::DEPTH,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    bit7_1to2_demux_if.slave    bus,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    cnt1,
    output logic [CNT_W-1:0]    cnt2
);
    import bit7_pkg::*;

    logic             full1, full2;
    logic             empty1, empty2;
    logic             push1, push2;
    logic             pop1, pop2;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] cnt2_q, cnt2_d;

    // Ready looks only at the selected channel's full flag; never at outN_ready.
    assign bus.in_ready = (bus.in_sel == SEL_OUT1) ? ~full1 : ~full2;

    assign push1 = bus.in_valid & bus.in_ready & (bus.in_sel == SEL_OUT1);
    assign push2 = bus.in_valid & bus.in_ready & (bus.in_sel == SEL_OUT2);

    assign bus.out1_valid = ~empty1;
    assign bus.out2_valid = ~empty2;
    assign pop1 = bus.out1_valid & bus.out1_ready;
    assign pop2 = bus.out2_valid & bus.out2_ready;

    bit7_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .din   (bus.in_data),
        .pop   (pop1),
        .dout  (bus.out1_data),
        .full  (full1),
        .empty (empty1)
    );

    bit7_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push2),
        .din   (bus.in_data),
        .pop   (pop2),
        .dout  (bus.out2_data),
        .full  (full2),
        .empty (empty2)
    );

    // Accept counters: clear wins over increment, wrap is natural modulo 2^CNT_W.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (clr_cnt) begin
            cnt1_d = '0;
            cnt2_d = '0;
        end else begin
            if (push1) cnt1_d = cnt1_q + 1'b1;
            if (push2) cnt2_d = cnt2_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
endmodule

// File: tb/tb_bit7_1to2_demux.sv
// Bench for bit7_1to2_demux: directed stimulus, occupancy model, scoreboard queues.
// Inputs change 1 time unit after the rising edge; everything is sampled on the falling edge.
// A snoop process predicts accepts and pushes expected words; a monitor pops on each output handshake.
module tb_bit7_1to2_demux;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_cnt;
    logic [7:0] cnt1, cnt2;

    bit7_1to2_demux_if #(.WIDTH(7)) bus ();

    bit7_1to2_demux #(.WIDTH(7), .DEPTH(D), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clr_cnt (clr_cnt),
        .cnt1    (cnt1),
        .cnt2    (cnt2)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] q1 [$];
    logic [6:0] q2 [$];
    int         occ1 = 0, occ2 = 0;
    logic [7:0] exp_cnt1 = 8'd0, exp_cnt2 = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts ready/valid/counters and queues expected words on predicted accepts.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ1 = 0; occ2 = 0;
            exp_cnt1 = 8'd0; exp_cnt2 = 8'd0;
            q1.delete(); q2.delete();
        end else begin
            bit p1, p2, d1, d2;
            check("in_ready", bus.in_ready, bus.in_sel ? (occ1 < D) : (occ2 < D));
            check("out1_valid", bus.out1_valid, occ1 != 0);
            check("out2_valid", bus.out2_valid, occ2 != 0);
            check("cnt1", cnt1, exp_cnt1);
            check("cnt2", cnt2, exp_cnt2);
            p1 = bus.in_valid && bus.in_sel && (occ1 < D);
            p2 = bus.in_valid && !bus.in_sel && (occ2 < D);
            d1 = (occ1 != 0) && bus.out1_ready;
            d2 = (occ2 != 0) && bus.out2_ready;
            if (p1) q1.push_back(bus.in_data);
            if (p2) q2.push_back(bus.in_data);
            occ1 = occ1 + int'(p1) - int'(d1);
            occ2 = occ2 + int'(p2) - int'(d2);
            if (clr_cnt) begin
                exp_cnt1 = 8'd0; exp_cnt2 = 8'd0;
            end else begin
                if (p1) exp_cnt1 = exp_cnt1 + 8'd1;
                if (p2) exp_cnt2 = exp_cnt2 + 8'd1;
            end
        end
    end

    // Monitor: on every output handshake compare the head word against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out1_valid && bus.out1_ready) begin
                if (q1.size() == 0) check("out1_unexpected", 1, 0);
                else check("out1_data", bus.out1_data, q1.pop_front());
            end
            if (bus.out2_valid && bus.out2_ready) begin
                if (q2.size() == 0) check("out2_unexpected", 1, 0);
                else check("out2_data", bus.out2_data, q2.pop_front());
            end
        end
    end

    // Present one word and hold it until accepted; cyc returns cycles spent.
    task automatic send(input logic sel, input logic [6:0] data, output int cyc);
        logic acc;
        acc = 1'b0;
        cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            cyc++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    int c, ca, cb, cc;

    initial begin
        rst_n = 1'b0;
        clr_cnt = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = 1'b1;
        bus.in_data = '0;
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state with idle inputs.
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out1_data", bus.out1_data, 0);
        check("rst_out2_data", bus.out2_data, 0);
        check("rst_cnt1", cnt1, 0);
        @(posedge clk); #1;

        // 55 to channel 1, then 2A to channel 2, consumers ready.
        send(1'b1, 7'h55, c);
        check("t2_first_accept", c, 1);
        send(1'b0, 7'h2A, c);
        @(negedge clk);
        check("t2_out2_data", bus.out2_data, 7'h2A);
        check("t2_cnt1", cnt1, 1);
        check("t2_cnt2", cnt2, 1);
        @(posedge clk); #1;

        // Stalled channel 1: third word waits until a slot frees.
        bus.out1_ready = 1'b0;
        fork
            begin
                send(1'b1, 7'h01, ca);
                send(1'b1, 7'h02, cb);
                send(1'b1, 7'h03, cc);
            end
            begin
                repeat (6) @(posedge clk);
                #1 bus.out1_ready = 1'b1;
            end
        join
        check("t3_a_accept", ca, 1);
        check("t3_b_accept", cb, 1);
        check("t3_c_stalled", cc > 1, 1);
        repeat (3) @(posedge clk); #1;

        // Channel 1 full, channel 2 still accepts; head-of-line block when back on channel 1.
        bus.out1_ready = 1'b0;
        send(1'b1, 7'h11, c);
        send(1'b1, 7'h12, c);
        send(1'b0, 7'h13, c);
        check("t4_other_channel", c, 1);
        bus.in_valid = 1'b1; bus.in_sel = 1'b1; bus.in_data = 7'h14;
        @(negedge clk);
        check("t4_blocked", bus.in_ready, 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-burst while channel 1 is full and a word is offered.
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_out1_valid", bus.out1_valid, 0);
        check("arst_out1_data", bus.out1_data, 0);
        check("arst_out2_valid", bus.out2_valid, 0);
        check("arst_cnt1", cnt1, 0);
        check("arst_cnt2", cnt2, 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out1_ready = 1'b1;
        send(1'b0, 7'h44, c);
        check("rel_first_accept", c, 1);

        // 256 pushes to channel 1 wrap its counter back to where it started (0).
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 7'(i), c);
        end
        @(negedge clk);
        check("wrap_cnt1", cnt1, 0);
        @(posedge clk); #1;

        // Clear in the same cycle as a channel-2 push: counter clears, word still lands.
        clr_cnt = 1'b1;
        send(1'b0, 7'h6B, c);
        clr_cnt = 1'b0;
        @(negedge clk);
        check("clr_cnt2", cnt2, 0);
        check("clr_out2_valid", bus.out2_valid, 1);
        check("clr_out2_data", bus.out2_data, 7'h6B);
        @(posedge clk); #1;

        // Alternating select stream at full rate: no stalls.
        for (int i = 0; i < 20; i++) begin
            send(i[0], 7'(8'h30 + i), c);
            check("stream_no_stall", c, 1);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain_q1", q1.size(), 0);
        check("drain_q2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
